// File: rtl/fetch_redirect_arbiter.sv
// Fetch redirect arbiter: picks one of PRED/ID/MEM redirect targets (oldest stage wins),
// holds a single pending target across decode stalls, and blocks younger redirects after a MEM correction.
module fetch_redirect_arbiter #(
  parameter int SQUASH_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             Pred_Req,
  input  logic [31:0]      Pred_PC,
  input  logic             ID_Req,
  input  logic [31:0]      ID_PC,
  input  logic             MEM_Req,
  input  logic [31:0]      MEM_PC,
  output logic             Request_Alt_PC,
  output logic [31:0]      Alt_PC,
  output logic [1:0]       Redirect_Src,
  output logic             Squash_Busy,
  output logic [CNT_W-1:0] Mispredict_Count
);

  localparam int SQ_W = (SQUASH_CYCLES > 2) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES - 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_PRED = 2'd1;
  localparam logic [1:0] SRC_ID   = 2'd2;
  localparam logic [1:0] SRC_MEM  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_SQUASH
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       buf_src_q, buf_src_d;
  logic [31:0]      buf_pc_q, buf_pc_d;
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic             req_q, req_d;
  logic [31:0]      alt_pc_q, alt_pc_d;
  logic [1:0]       src_q, src_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  // Source codes double as priority ranks, so comparisons below are priority comparisons.
  logic [1:0]  new_src;
  logic [31:0] new_pc;

  always_comb begin
    new_src = SRC_NONE;
    new_pc  = '0;
    if (MEM_Req) begin
      new_src = SRC_MEM;
      new_pc  = MEM_PC;
    end else if (ID_Req) begin
      new_src = SRC_ID;
      new_pc  = ID_PC;
    end else if (Pred_Req) begin
      new_src = SRC_PRED;
      new_pc  = Pred_PC;
    end
  end

  logic        issue_en;
  logic [1:0]  issue_src;
  logic [31:0] issue_pc;

  always_comb begin
    state_d   = state_q;
    buf_src_d = buf_src_q;
    buf_pc_d  = buf_pc_q;
    sq_cnt_d  = sq_cnt_q;
    req_d     = 1'b0;
    alt_pc_d  = alt_pc_q;
    src_d     = src_q;
    mcnt_d    = mcnt_q;
    issue_en  = 1'b0;
    issue_src = SRC_NONE;
    issue_pc  = '0;

    case (state_q)
      S_IDLE: begin
        if (new_src != SRC_NONE) begin
          if (STALL) begin
            buf_src_d = new_src;
            buf_pc_d  = new_pc;
            state_d   = S_PENDING;
          end else begin
            issue_en  = 1'b1;
            issue_src = new_src;
            issue_pc  = new_pc;
          end
        end
      end
      S_PENDING: begin
        if (STALL) begin
          if (new_src != SRC_NONE && new_src >= buf_src_q) begin
            buf_src_d = new_src;
            buf_pc_d  = new_pc;
          end
        end else begin
          issue_en = 1'b1;
          if (new_src > buf_src_q) begin
            issue_src = new_src;
            issue_pc  = new_pc;
          end else begin
            issue_src = buf_src_q;
            issue_pc  = buf_pc_q;
          end
        end
      end
      S_SQUASH: begin
        // Only a further MEM correction may break through the squash window.
        if (MEM_Req) begin
          if (STALL) begin
            buf_src_d = SRC_MEM;
            buf_pc_d  = MEM_PC;
            sq_cnt_d  = '0;
            state_d   = S_PENDING;
          end else begin
            issue_en  = 1'b1;
            issue_src = SRC_MEM;
            issue_pc  = MEM_PC;
          end
        end else if (sq_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          sq_cnt_d = sq_cnt_q - SQ_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue_en) begin
      req_d     = 1'b1;
      alt_pc_d  = issue_pc & ~32'h3;
      src_d     = issue_src;
      buf_src_d = SRC_NONE;
      if (issue_src == SRC_MEM) begin
        state_d  = S_SQUASH;
        sq_cnt_d = SQ_LOAD;
        if (mcnt_q != '1) begin
          mcnt_d = mcnt_q + CNT_W'(1);
        end
      end else begin
        state_d  = S_IDLE;
        sq_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      buf_src_q <= SRC_NONE;
      buf_pc_q  <= '0;
      sq_cnt_q  <= '0;
      req_q     <= 1'b0;
      alt_pc_q  <= '0;
      src_q     <= SRC_NONE;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      buf_src_q <= buf_src_d;
      buf_pc_q  <= buf_pc_d;
      sq_cnt_q  <= sq_cnt_d;
      req_q     <= req_d;
      alt_pc_q  <= alt_pc_d;
      src_q     <= src_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign Request_Alt_PC   = req_q;
  assign Alt_PC           = alt_pc_q;
  assign Redirect_Src     = src_q;
  assign Squash_Busy      = (state_q == S_SQUASH);
  assign Mispredict_Count = mcnt_q;

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Directed bench for fetch_redirect_arbiter; a second instance with a 4-bit counter
// shares all inputs so counter saturation can be observed alongside the default build.
module tb_fetch_redirect_arbiter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pred_req, id_req, mem_req;
  logic [31:0] pred_pc, id_pc, mem_pc;
  logic        req, req4;
  logic [31:0] alt_pc, alt_pc4;
  logic [1:0]  src, src4;
  logic        busy, busy4;
  logic [15:0] mcnt;
  logic [3:0]  mcnt4;

  int n_vec = 0;
  int n_bad = 0;

  fetch_redirect_arbiter u_dut (
    .CLK(clk), .RESET(rst), .STALL(stall),
    .Pred_Req(pred_req), .Pred_PC(pred_pc),
    .ID_Req(id_req), .ID_PC(id_pc),
    .MEM_Req(mem_req), .MEM_PC(mem_pc),
    .Request_Alt_PC(req), .Alt_PC(alt_pc), .Redirect_Src(src),
    .Squash_Busy(busy), .Mispredict_Count(mcnt)
  );

  fetch_redirect_arbiter #(.SQUASH_CYCLES(8), .CNT_W(4)) u_dut4 (
    .CLK(clk), .RESET(rst), .STALL(stall),
    .Pred_Req(pred_req), .Pred_PC(pred_pc),
    .ID_Req(id_req), .ID_PC(id_pc),
    .MEM_Req(mem_req), .MEM_PC(mem_pc),
    .Request_Alt_PC(req4), .Alt_PC(alt_pc4), .Redirect_Src(src4),
    .Squash_Busy(busy4), .Mispredict_Count(mcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("vec %0d %s = 0x%08h ok", n_vec, tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    pred_req = 1'b0; id_req = 1'b0; mem_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; clear_reqs();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, " req"},  {31'd0, req},  32'd0);
    check_val({tag, " alt"},  alt_pc,        32'd0);
    check_val({tag, " src"},  {30'd0, src},  32'd0);
    check_val({tag, " busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, " cnt"},  {16'd0, mcnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clear_reqs();
    pred_pc = '0; id_pc = '0; mem_pc = '0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_val("idle req", {31'd0, req}, 32'd0);

    // Same-cycle PRED and ID: ID wins
    pred_req = 1'b1; pred_pc = 32'h0040_0010;
    id_req   = 1'b1; id_pc   = 32'h0040_0100;
    tick();
    clear_reqs();
    check_val("prio req",  {31'd0, req},  32'd1);
    check_val("prio alt",  alt_pc,        32'h0040_0100);
    check_val("prio src",  {30'd0, src},  32'd2);
    check_val("prio busy", {31'd0, busy}, 32'd0);
    tick();
    check_val("prio strobe1", {31'd0, req}, 32'd0);
    check_val("prio hold",    alt_pc,       32'h0040_0100);

    // MEM redirect with misaligned PC, then 8-cycle squash that swallows an ID request
    mem_req = 1'b1; mem_pc = 32'h0040_0203;
    tick();
    clear_reqs();
    check_val("mem req",  {31'd0, req},  32'd1);
    check_val("mem alt",  alt_pc,        32'h0040_0200);
    check_val("mem src",  {30'd0, src},  32'd3);
    check_val("mem busy", {31'd0, busy}, 32'd1);
    check_val("mem cnt",  {16'd0, mcnt}, 32'd1);
    for (int i = 2; i <= 8; i++) begin
      id_req = (i == 3); id_pc = 32'h0040_0500;
      tick();
      check_val($sformatf("squash%0d busy", i), {31'd0, busy}, 32'd1);
      check_val($sformatf("squash%0d req", i),  {31'd0, req},  32'd0);
    end
    id_req = 1'b0;
    tick();
    check_val("squash end busy", {31'd0, busy}, 32'd0);
    check_val("squash end req",  {31'd0, req},  32'd0);
    check_val("squash end src",  {30'd0, src},  32'd3);

    // Stalled: PRED buffered, overwritten by MEM, issued after STALL falls
    stall = 1'b1;
    pred_req = 1'b1; pred_pc = 32'h0040_0040;
    tick();
    check_val("stall1 req", {31'd0, req}, 32'd0);
    pred_req = 1'b0; mem_req = 1'b1; mem_pc = 32'h0040_0080;
    tick();
    check_val("stall2 req", {31'd0, req}, 32'd0);
    mem_req = 1'b0;
    tick();
    check_val("stall3 req", {31'd0, req}, 32'd0);
    tick();
    check_val("stall4 req",  {31'd0, req},  32'd0);
    check_val("stall4 busy", {31'd0, busy}, 32'd0);
    stall = 1'b0;
    tick();
    check_val("unstall req",  {31'd0, req},  32'd1);
    check_val("unstall alt",  alt_pc,        32'h0040_0080);
    check_val("unstall src",  {30'd0, src},  32'd3);
    check_val("unstall busy", {31'd0, busy}, 32'd1);
    check_val("unstall cnt",  {16'd0, mcnt}, 32'd2);
    tick();
    check_val("unstall once", {31'd0, req}, 32'd0);

    // Higher-priority request arriving in the unstall cycle beats the buffer
    do_reset();
    stall = 1'b1; pred_req = 1'b1; pred_pc = 32'h0040_0050;
    tick();
    check_val("pend pred req", {31'd0, req}, 32'd0);
    stall = 1'b0; pred_req = 1'b0; id_req = 1'b1; id_pc = 32'h0040_0062;
    tick();
    clear_reqs();
    check_val("pend win req", {31'd0, req}, 32'd1);
    check_val("pend win alt", alt_pc,       32'h0040_0060);
    check_val("pend win src", {30'd0, src}, 32'd2);
    tick();

    // Lower-priority request while stalled is dropped
    stall = 1'b1; id_req = 1'b1; id_pc = 32'h0040_0070;
    tick();
    id_req = 1'b0; pred_req = 1'b1; pred_pc = 32'h0040_0074;
    tick();
    check_val("drop req", {31'd0, req}, 32'd0);
    stall = 1'b0; pred_req = 1'b0;
    tick();
    check_val("drop issue req", {31'd0, req}, 32'd1);
    check_val("drop issue alt", alt_pc,       32'h0040_0070);
    check_val("drop issue src", {30'd0, src}, 32'd2);
    tick();

    // Reset in PENDING, with a request held high during reset
    stall = 1'b1; pred_req = 1'b1; pred_pc = 32'h0040_0044;
    tick();
    pred_req = 1'b0; rst = 1'b1; id_req = 1'b1; id_pc = 32'h0040_0088;
    tick();
    check_zero("rst pend");
    rst = 1'b0; id_req = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("post rst pend %0d req", i), {31'd0, req}, 32'd0);
    end

    // Reset at squash cycle 4
    mem_req = 1'b1; mem_pc = 32'h0040_0300;
    tick();
    mem_req = 1'b0;
    check_val("sq4 issue req", {31'd0, req}, 32'd1);
    tick(); tick(); tick();
    check_val("sq4 busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check_zero("rst squash");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("post rst sq %0d req", i),  {31'd0, req},  32'd0);
      check_val($sformatf("post rst sq %0d busy", i), {31'd0, busy}, 32'd0);
    end

    // 17 back-to-back MEM issues: 4-bit counter saturates at 15
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      mem_pc = 32'h0041_0000 + 32'(i * 4);
      tick();
      check_val($sformatf("sat%0d req", i), {31'd0, req4}, 32'd1);
      check_val($sformatf("sat%0d cnt4", i), {28'd0, mcnt4}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    mem_req = 1'b0;
    check_val("sat cnt16", {16'd0, mcnt}, 32'd17);
    check_val("sat alt",   alt_pc,        32'h0041_0040);
    tick();
    check_val("sat hold cnt4", {28'd0, mcnt4}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_arbiter.md
FETCH_REDIRECT_ARBITER -- requirements
Module: fetch_redirect_arbiter

Interface
REQ-001 Parameter SQUASH_CYCLES, default 8: cycles that younger redirects stay blocked after an issued MEM redirect (covers IF plus 7 buffer stages).
REQ-002 Parameter CNT_W, default 16: width of the mispredict counter.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 STALL  in  1  fetch freeze from decode; an issue cannot complete while high.
REQ-006 Pred_Req / Pred_PC  in  1 / 32  predicted-taken target from the fetch-side predictor.
REQ-007 ID_Req / ID_PC  in  1 / 32  jump target resolved in decode.
REQ-008 MEM_Req / MEM_PC  in  1 / 32  mispredict correction resolved in memory stage.
REQ-009 Request_Alt_PC  out  1  registered one-cycle redirect strobe to fetch.
REQ-010 Alt_PC  out  32  registered redirect target, valid when Request_Alt_PC=1.
REQ-011 Redirect_Src  out  2  source of the current or last issue: 0 none, 1 PRED, 2 ID, 3 MEM.
REQ-012 Squash_Busy  out  1  high while in SQUASH.
REQ-013 Mispredict_Count  out  CNT_W  saturating count of issued MEM redirects.

Function
REQ-014 Priority SHALL be MEM > ID > PRED, oldest stage wins; lower-priority same-cycle requests are dropped, not queued.
REQ-015 FSM states SHALL be IDLE, PENDING, SQUASH.
REQ-016 IDLE, any request, STALL=0: issue winner next cycle with Request_Alt_PC=1, Alt_PC=winner PC; go to SQUASH if MEM, else IDLE.
REQ-017 IDLE, any request, STALL=1: latch winner PC and source into a one-entry buffer; go to PENDING.
REQ-018 PENDING, STALL=1: a new request of equal or higher priority SHALL overwrite the buffer; lower priority is dropped.
REQ-019 PENDING, STALL=0: issue the buffer as in REQ-016, or the higher-priority new request if one arrives the same cycle.
REQ-020 SQUASH: down-counter loaded with SQUASH_CYCLES-1 on entry, decrements each cycle regardless of STALL; PRED and ID requests ignored; return to IDLE when counter reaches 0.
REQ-021 SQUASH, MEM_Req: treated as in IDLE (issue or PENDING per STALL); counter reloaded on the resulting MEM issue.
REQ-022 Request_Alt_PC SHALL be high exactly one cycle per issue, never while STALL was high in the deciding cycle.
REQ-023 Alt_PC[1:0] SHALL be forced to 2'b00; Alt_PC holds its last value when Request_Alt_PC=0.
REQ-024 Mispredict_Count SHALL increment on each issued MEM redirect and saturate at all-ones.
REQ-025 Latency: request to Request_Alt_PC is exactly 1 cycle when unstalled; when stalled, 1 cycle after the first STALL=0 cycle.

Reset
REQ-026 While RESET=1 at a clock edge: state=IDLE, buffer invalid, squash counter=0, Request_Alt_PC=0, Alt_PC=0, Redirect_Src=0, Squash_Busy=0, Mispredict_Count=0.
REQ-027 RESET in PENDING or SQUASH SHALL discard the buffered request with no issue; requests asserted during reset are ignored.

Verification
REQ-028 Same cycle: Pred_Req=1 with Pred_PC=0x400010, ID_Req=1 with ID_PC=0x400100, STALL=0 -> next cycle Request_Alt_PC=1, Alt_PC=0x400100, Redirect_Src=2; FSM back in IDLE.
REQ-029 MEM_Req=1 with MEM_PC=0x400203 -> Alt_PC=0x400200, Redirect_Src=3, Squash_Busy=1 for 8 cycles, Mispredict_Count=1; ID_Req pulsed in cycle 3 of squash -> no issue.
REQ-030 STALL=1 for 4 cycles; PRED request (0x400040) in cycle 1, MEM request (0x400080) in cycle 2 -> no strobe while stalled; one strobe with 0x400080 the cycle after STALL falls.
REQ-031 CNT_W=4; 17 MEM issues -> Mispredict_Count reaches 15 and holds.
REQ-032 RESET asserted in PENDING and again at squash cycle 4 -> all outputs zero next cycle; no strobe after RESET deasserts without a new request.
